// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM instructions into one single-register micro-op per set list bit,
// stalling PC and IF/ID and bubbling the raw instruction while the sequence runs.
module lm_sm_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LIST_W = 8,
    parameter logic [3:0]  OPC_LM = 4'b0110,
    parameter logic [3:0]  OPC_SM = 4'b0111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              uop_ready,
    output logic              uop_valid,
    output logic              uop_is_load,
    output logic [2:0]        uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_last,
    output logic              pc_if_id_write,
    output logic              id_bubble,
    output logic              busy
);

    typedef enum logic [0:0] {StIdle, StSeq} state_e;

    state_e              state_q, state_d;
    logic [LIST_W-1:0]   list_q, list_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_load_q, is_load_d;

    logic [3:0]          opcode;
    logic                is_lsm;
    logic                capture;
    logic [2:0]          low_idx;
    logic                last_bit;

    assign opcode  = instr[15:12];
    assign is_lsm  = (opcode == OPC_LM) || (opcode == OPC_SM);
    assign capture = (state_q == StIdle) && instr_valid && !flush && is_lsm &&
                     (instr[LIST_W-1:0] != '0);

    // Priority scan from the top so the lowest set bit wins.
    always_comb begin
        low_idx = 3'd0;
        for (int unsigned i = LIST_W; i > 0; i--) begin
            if (list_q[i-1]) low_idx = 3'(i - 1);
        end
    end

    assign last_bit = (list_q != '0) && ((list_q & (list_q - LIST_W'(1))) == '0);

    always_comb begin
        state_d        = state_q;
        list_d         = list_q;
        addr_d         = addr_q;
        is_load_d      = is_load_q;
        uop_valid      = 1'b0;
        pc_if_id_write = 1'b1;
        id_bubble      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    list_d         = instr[LIST_W-1:0];
                    addr_d         = base_addr;
                    is_load_d      = (opcode == OPC_LM);
                    state_d        = StSeq;
                    pc_if_id_write = 1'b0;
                    id_bubble      = 1'b1;
                end
            end
            StSeq: begin
                if (!flush) begin
                    uop_valid      = 1'b1;
                    id_bubble      = 1'b1;
                    // Release the stall exactly when the final micro-op leaves.
                    pc_if_id_write = uop_ready && last_bit;
                    if (uop_ready) begin
                        list_d = list_q & (list_q - LIST_W'(1));
                        addr_d = addr_q + ADDR_W'(1);
                        if (last_bit) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
            list_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            list_q    <= '0;
            addr_q    <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            is_load_q <= is_load_d;
        end
    end

    assign busy        = (state_q == StSeq);
    assign uop_reg     = busy ? low_idx : 3'd0;
    assign uop_addr    = busy ? addr_q : '0;
    assign uop_is_load = busy && is_load_q;
    assign uop_last    = busy && last_bit;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed scenarios then random traffic, all checked
// against a queue-based model of the micro-op stream.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] base_addr;
    logic        flush;
    logic        uop_ready;
    logic        uop_valid;
    logic        uop_is_load;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        uop_last;
    logic        pc_if_id_write;
    logic        id_bubble;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pending micro-ops as (register, address) queues.
    logic        m_busy = 1'b0;
    logic        m_load = 1'b0;
    int          m_reg_q[$];
    logic [15:0] m_addr_q[$];

    lm_sm_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .base_addr      (base_addr),
        .flush          (flush),
        .uop_ready      (uop_ready),
        .uop_valid      (uop_valid),
        .uop_is_load    (uop_is_load),
        .uop_reg        (uop_reg),
        .uop_addr       (uop_addr),
        .uop_last       (uop_last),
        .pc_if_id_write (pc_if_id_write),
        .id_bubble      (id_bubble),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 1'b0;
        m_reg_q.delete();
        m_addr_q.delete();
    endtask

    // Drive one cycle at the negedge, check outputs mid-cycle, advance the model at posedge.
    task automatic step(input string name, input logic iv, input logic [15:0] ins,
                        input logic [15:0] base, input logic fl, input logic rdy);
        logic cap, e_valid, e_pc, e_bub;
        instr_valid = iv;
        instr       = ins;
        base_addr   = base;
        flush       = fl;
        uop_ready   = rdy;
        #1;
        cap = !m_busy && iv && !fl && (ins[15:12] == 4'h6 || ins[15:12] == 4'h7) &&
              (ins[7:0] != 8'h00);
        e_valid = m_busy && !fl;
        if (fl)          e_pc = 1'b1;
        else if (m_busy) e_pc = rdy && (m_reg_q.size() == 1);
        else             e_pc = !cap;
        e_bub = !fl && (m_busy || cap);
        chk({name, ".valid"}, 16'(uop_valid), 16'(e_valid));
        chk({name, ".busy"}, 16'(busy), 16'(m_busy));
        chk({name, ".pcw"}, 16'(pc_if_id_write), 16'(e_pc));
        chk({name, ".bubble"}, 16'(id_bubble), 16'(e_bub));
        if (e_valid) begin
            chk({name, ".reg"}, 16'(uop_reg), 16'(m_reg_q[0]));
            chk({name, ".addr"}, uop_addr, m_addr_q[0]);
            chk({name, ".load"}, 16'(uop_is_load), 16'(m_load));
            chk({name, ".last"}, 16'(uop_last), 16'(m_reg_q.size() == 1));
        end
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else if (m_busy) begin
            if (rdy) begin
                void'(m_reg_q.pop_front());
                void'(m_addr_q.pop_front());
                if (m_reg_q.size() == 0) m_busy = 1'b0;
            end
        end else if (cap) begin
            int k = 0;
            for (int i = 0; i < 8; i++) begin
                if (ins[i]) begin
                    m_reg_q.push_back(i);
                    m_addr_q.push_back(base + 16'(k));
                    k++;
                end
            end
            m_load = (ins[15:12] == 4'h6);
            m_busy = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; base_addr = '0; flush = 1'b0;
        uop_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst.valid", 16'(uop_valid), 16'd0);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.pcw", 16'(pc_if_id_write), 16'd1);
        chk("rst.bubble", 16'(id_bubble), 16'd0);
        chk("rst.reg", 16'(uop_reg), 16'd0);
        chk("rst.addr", uop_addr, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // LM R0,R2,R7 from 0x0100
        step("t1.cap", 1'b1, 16'h6085, 16'h0100, 1'b0, 1'b1);
        step("t1.u0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t1.u1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t1.u2", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t1.idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // SM with empty list passes through
        step("t2.nop", 1'b1, 16'h7000, 16'h1234, 1'b0, 1'b1);
        step("t2.after", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // SM R0,R1 with back-pressure
        step("t3.cap", 1'b1, 16'h7003, 16'h0200, 1'b0, 1'b0);
        step("t3.hold0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("t3.hold1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("t3.u0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t3.u1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t3.idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Address wrap
        step("t4.cap", 1'b1, 16'h60C0, 16'hFFFF, 1'b0, 1'b1);
        step("t4.u0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        chk("t4.wrap_addr", uop_addr, 16'h0000);
        step("t4.u1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Flush after the second accept
        step("t5.cap", 1'b1, 16'h60FF, 16'h0040, 1'b0, 1'b1);
        step("t5.u0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t5.u1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step("t5.flush", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        step("t5.idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Asynchronous reset mid-sequence
        step("t6.cap", 1'b1, 16'h70FF, 16'h0800, 1'b0, 1'b1);
        step("t6.u0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6.rst.valid", 16'(uop_valid), 16'd0);
        chk("t6.rst.busy", 16'(busy), 16'd0);
        chk("t6.rst.pcw", 16'(pc_if_id_write), 16'd1);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step("t6.idle", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ins;
            logic [3:0]  opc;
            logic [7:0]  lst;
            case ($urandom_range(0, 3))
                0:       opc = 4'h6;
                1:       opc = 4'h7;
                default: opc = 4'($urandom);
            endcase
            lst = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            ins = {opc, 4'($urandom), lst};
            step("rnd", $urandom_range(0, 7) != 0, ins, 16'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
